// File: rtl/imm_ext_arbiter_pkg.sv
// Shared processor package: immediate extension widths and output-stage state encoding.
package imm_ext_arbiter_pkg;

  localparam int unsigned IMM_IN_W  = 12;
  localparam int unsigned IMM_OUT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage : imm_ext_arbiter_pkg

// File: rtl/imm_ext_arbiter_extend.sv
// imm_extend_unit: combinational zero/sign extension of an immediate field.
// Sign extension is honoured only when IMM_EXT_SIGN_EN is defined.
module imm_extend_unit
  import imm_ext_arbiter_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  i_field,
  input  logic             i_sign,
  output logic [OUT_W-1:0] o_ext
);

  logic w_fill;

`ifdef IMM_EXT_SIGN_EN
  assign w_fill = i_sign & i_field[IN_W-1];
`else
  logic w_unused_sign;
  assign w_unused_sign = i_sign;
  assign w_fill        = 1'b0;
`endif

  assign o_ext = {{(OUT_W-IN_W){w_fill}}, i_field};

endmodule : imm_extend_unit

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding one registered immediate-extension output stage.
// Optional macro IMM_EXT_SIGN_EN enables per-request sign extension.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int unsigned IN_W  = IMM_IN_W,
  parameter int unsigned OUT_W = IMM_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_field,
  input  logic             req0_sign,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_field,
  input  logic             req1_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_src
);

  if (OUT_W <= IN_W) begin : g_width_check
    $error("imm_ext_arbiter: OUT_W must exceed IN_W");
  end

  out_state_e       r_state, w_state_nxt;
  logic             r_last_grant;
  logic [OUT_W-1:0] r_data;
  logic             r_src;

  logic             w_can_accept;
  logic             w_grant0, w_grant1, w_grant_any, w_grant_idx;
  logic [IN_W-1:0]  w_sel_field;
  logic             w_sel_sign;
  logic [OUT_W-1:0] w_ext;

  assign w_can_accept = (r_state == ST_EMPTY) || out_ready;

  // On a tie the requester that did not win last time takes the slot.
  assign w_grant0    = w_can_accept & req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1    = w_can_accept & req1_valid & (~req0_valid | ~r_last_grant);
  assign w_grant_any = w_grant0 | w_grant1;
  assign w_grant_idx = w_grant1;

  assign w_sel_field = w_grant_idx ? req1_field : req0_field;
  assign w_sel_sign  = w_grant_idx ? req1_sign  : req0_sign;

  imm_extend_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_extend (
    .i_field (w_sel_field),
    .i_sign  (w_sel_sign),
    .o_ext   (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant_any) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_data       <= '0;
      r_src        <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_any) begin
        r_data       <= w_ext;
        r_src        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign out_valid  = (r_state == ST_FULL);
  assign out_data   = r_data;
  assign out_src    = r_src;

endmodule : imm_ext_arbiter

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter IN_W, default 12: width of the immediate field presented by each requester.
REQ-002 Parameter OUT_W, default 16: width of the extended result; SHALL be greater than IN_W.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req0_valid, input, 1: requester 0 (decode immediate) presents a field.
REQ-006 Port req0_ready, output, 1: requester 0 field is accepted this cycle.
REQ-007 Port req0_field, input, IN_W: requester 0 raw field.
REQ-008 Port req0_sign, input, 1: requester 0 asks for sign extension (1) or zero extension (0).
REQ-009 Ports req1_valid, req1_ready, req1_field, req1_sign: same as REQ-005 to REQ-008, for requester 1 (branch offset).
REQ-010 Port out_valid, output, 1: out_data holds a valid result.
REQ-011 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-012 Port out_data, output, OUT_W: the extended value.
REQ-013 Port out_src, output, 1: index of the requester that produced out_data.

Function
REQ-014 Transfers SHALL use a valid/ready handshake: a transfer happens when valid and ready are both 1 on a rising clk edge.
REQ-015 Output stage FSM SHALL have two states:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
REQ-016 The arbiter SHALL be able to accept a request when the state is EMPTY, or when the state is FULL and out_ready=1.
REQ-017 When it can accept and exactly one reqN_valid=1, that requester SHALL be granted.
REQ-018 When it can accept and both valids are 1, the requester not granted last (last_grant pointer) SHALL be granted.
REQ-019 reqN_ready SHALL be 1 only for the granted requester; at most one ready is high per cycle; ready is combinational from the valids, the state and out_ready.
REQ-020 On a grant, the extended field SHALL be registered in out_data, the requester index in out_src, the state SHALL become FULL, and last_grant SHALL be updated.
- Latency: 1 cycle from accept to out_valid.
REQ-021 Zero extension SHALL place OUT_W-IN_W zero bits above the field; sign extension SHALL replicate field bit IN_W-1 into those bits.
REQ-022 In FULL with out_ready=1 and no grant, the state SHALL return to EMPTY.
REQ-023 In FULL with out_ready=1 and a grant, the state SHALL stay FULL and load the new value (one result per cycle, no bubble).
REQ-024 In FULL with out_ready=0, out_data and out_src SHALL hold stable and both readies SHALL be 0.
REQ-025 A requester that drops valid before it is granted SHALL lose nothing; no request is queued internally.

Reset
REQ-026 While rst_n=0: state=EMPTY, out_valid=0, out_data=0, out_src=0, last_grant=1 (requester 0 wins the first tie).
REQ-027 Asserting reset mid-operation SHALL discard any held result immediately and asynchronously; no partial transfer completes.
REQ-028 After reset release, the first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-029 Macro IMM_EXT_SIGN_EN defined: reqN_sign SHALL select sign extension per REQ-021.
REQ-030 Macro IMM_EXT_SIGN_EN undefined: reqN_sign SHALL be ignored and all results SHALL be zero-extended.

Structure
REQ-031 The shared processor package SHALL hold the IN_W/OUT_W defaults and the EMPTY/FULL state encoding.
REQ-032 The extension SHALL be a combinational sub-module imm_extend_unit (field, sign -> extended value), instanced once on the granted field.

Verification
REQ-033 Reset, then req0 only: req0_field=0xABC, sign=0, out_ready=1 -> next cycle out_valid=1, out_data=0x0ABC, out_src=0.
REQ-034 With IMM_EXT_SIGN_EN defined: req1_field=0x800, sign=1 -> out_data=0xF800, out_src=1; same stimulus with the macro undefined -> out_data=0x0800.
REQ-035 Both valid for 4 cycles, out_ready=1 -> grants in order 0,1,0,1; out_valid stays high with no bubble.
REQ-036 out_ready=0 while FULL with out_data=0x0123, req0_valid=1 for 3 cycles -> both readies 0 and out_data stays 0x0123; out_ready=1 -> out_data loads the req0 value next cycle.
REQ-037 rst_n pulled low while FULL -> out_valid=0 and out_data=0 without waiting for clk; first tie after release goes to requester 0.
